// File: rtl/fsk_frame_if.sv
// Bit-stream and frame-output bundle between bit_syn's output side and the
// frame controller; the controller takes the slave view.
interface fsk_frame_if;
    logic       bit_in;
    logic       bit_vld;
    logic       syn_en;
    logic [7:0] data_out;
    logic       data_vld;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] led;
    logic [1:0] state_o;

    modport master (
        output bit_in, bit_vld,
        input  syn_en, data_out, data_vld, frame_done, frame_err, led, state_o
    );

    modport slave (
        input  bit_in, bit_vld,
        output syn_en, data_out, data_vld, frame_done, frame_err, led, state_o
    );
endinterface

// File: rtl/fsk_frame_ctrl.sv
// Receive-side frame controller: debounced key arms bit_syn, hunts for the
// sync word, assembles fixed-length frames into bytes and counts good frames.
module fsk_frame_ctrl #(
    parameter logic [15:0] SYNC_WORD   = 16'hEB90,
    parameter int          FRAME_BYTES = 8,
    parameter int          TIMEOUT     = 20000,
    parameter int          DEB_CNT     = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key,
    fsk_frame_if.slave   bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [7:0]       LAST_BYTE = 8'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HUNT = 2'b01,
        ST_RECV = 2'b10
    } state_t;

    logic             key_meta_q, key_meta_d;
    logic             key_sync_q, key_sync_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_s;

    state_t           state_q, state_d;
    // Only 15 history bits are kept; the incoming bit completes the 16-bit window.
    logic [14:0]      sr_q, sr_d;
    logic [6:0]       byte_q, byte_d;
    logic [7:0]       byte_asm_s;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             syn_en_q, syn_en_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_vld_q, data_vld_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       led_q, led_d;

    // Key synchronizer and debounce: level flips after DEB_CNT disagreeing cycles.
    always_comb begin
        key_meta_d = key;
        key_sync_d = key_meta_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        if (key_sync_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = key_sync_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
        press_s = deb_q & ~deb_d;
    end

    assign byte_asm_s = {byte_q, bus.bit_in};

    // Frame FSM next-state and registered-output computation; a press overrides all.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        byte_d       = byte_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_d        = tmo_q;
        data_out_d   = data_out_q;
        data_vld_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        led_d        = led_q;

        if (press_s) begin
            sr_d       = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            tmo_d      = '0;
            if (state_q == ST_IDLE) begin
                state_d = ST_HUNT;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HUNT: begin
                    if (bus.bit_vld) begin
                        sr_d = {sr_q[13:0], bus.bit_in};
                        if ({sr_q, bus.bit_in} == SYNC_WORD) begin
                            state_d    = ST_RECV;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                            tmo_d      = '0;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_RECV: begin
                    if (bus.bit_vld) begin
                        byte_d = byte_asm_s[6:0];
                        tmo_d  = '0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d  = '0;
                            data_out_d = byte_asm_s;
                            data_vld_d = 1'b1;
                            if (byte_cnt_q == LAST_BYTE) begin
                                frame_done_d = 1'b1;
                                led_d        = led_q + 8'd1;
                                state_d      = ST_HUNT;
                                sr_d         = '0;
                                byte_cnt_d   = '0;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                        sr_d        = '0;
                        tmo_d       = '0;
                        bit_cnt_d   = '0;
                        byte_cnt_d  = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    sr_d       = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                end
            endcase
        end

        syn_en_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q   <= 1'b1;
            key_sync_q   <= 1'b1;
            deb_q        <= 1'b1;
            deb_cnt_q    <= '0;
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            byte_q       <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            syn_en_q     <= 1'b0;
            data_out_q   <= 8'd0;
            data_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            led_q        <= 8'd0;
        end else begin
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            byte_q       <= byte_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            syn_en_q     <= syn_en_d;
            data_out_q   <= data_out_d;
            data_vld_q   <= data_vld_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            led_q        <= led_d;
        end
    end

    assign bus.syn_en     = syn_en_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_vld   = data_vld_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.led        = led_q;
    assign bus.state_o    = state_q;

endmodule
